// File: rtl/psum_mem_seq_pkg.sv
// psum_mem_seq_pkg: shared types and constants for the psum memory-side sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, SRAM active-low control levels.
package psum_mem_seq_pkg;

  // Sequencer states: wait for start, accept row + read, present to SFU,
  // write back, signal completion.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_ACC  = 3'd2,
    S_WB   = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  // SRAM control pins are active-low.
  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;
  localparam logic WEN_WR  = 1'b0;
  localparam logic WEN_RD  = 1'b1;

endpackage

// File: rtl/psum_mem_seq.sv
// psum_mem_seq: pairs array psum rows with stored SRAM psum rows for the SFU bank
// and writes the bank's result back to the same address, num_rows rows per start.
// Latency: row accepted in RD -> SFU valid next cycle -> SRAM write the cycle after;
// one row per 3 cycles. Backpressure: holds in RD (in_ready=1, SRAM idle) until in_valid.
// Ports: clk/reset; start/base_addr/num_rows/acc_en command; in_valid/in_ready/in_data
// row input; mem_* single-port SRAM; sfu_* SFU bank interface; busy/done status.
module psum_mem_seq
  import psum_mem_seq_pkg::*;
#(
  parameter int psum_bw = 32,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [addr_bw-1:0]     num_rows,
  input  logic                   acc_en,
  input  logic                   in_valid,
  input  logic [col*psum_bw-1:0] in_data,
  output logic                   in_ready,
  output logic                   mem_cen,
  output logic                   mem_wen,
  output logic [addr_bw-1:0]     mem_addr,
  output logic [col*psum_bw-1:0] mem_din,
  input  logic [col*psum_bw-1:0] mem_dout,
  output logic                   sfu_valid,
  output logic [col*psum_bw-1:0] sfu_psum_in,
  output logic [col*psum_bw-1:0] sfu_psum_mem,
  input  logic [col*psum_bw-1:0] sfu_psum_out,
  output logic                   busy,
  output logic                   done
);

  localparam int ROW_W = col * psum_bw;
  localparam logic [addr_bw-1:0] ONE = addr_bw'(1);

  state_e             state_q,    state_d;
  logic [addr_bw-1:0] addr_q,     addr_d;
  logic [addr_bw-1:0] row_cnt_q,  row_cnt_d;
  logic [addr_bw-1:0] num_rows_q, num_rows_d;
  logic               acc_en_q,   acc_en_d;
  logic [ROW_W-1:0]   row_q,      row_d;
  // Hold registers: the SRAM and SFU data outputs keep their last driven value
  // while unused, so the live value is muxed in only in the cycle that uses it.
  logic [addr_bw-1:0] mem_addr_q, mem_addr_d;
  logic [ROW_W-1:0]   mem_din_q,  mem_din_d;
  logic [ROW_W-1:0]   psum_mem_q, psum_mem_d;

  // The row register only changes on acceptance, so it already holds between rows.
  assign sfu_psum_in = row_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    row_cnt_d    = row_cnt_q;
    num_rows_d   = num_rows_q;
    acc_en_d     = acc_en_q;
    row_d        = row_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    psum_mem_d   = psum_mem_q;

    in_ready     = 1'b0;
    mem_cen      = CEN_OFF;
    mem_wen      = WEN_RD;
    mem_addr     = mem_addr_q;
    mem_din      = mem_din_q;
    sfu_valid    = 1'b0;
    sfu_psum_mem = psum_mem_q;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_rows_d = num_rows;
          acc_en_d   = acc_en;
          addr_d     = base_addr;
          row_cnt_d  = '0;
          state_d    = (num_rows == '0) ? S_FIN : S_RD;
        end
      end

      S_RD: begin
        in_ready = 1'b1;
        // The read is issued in the same cycle the row is accepted so the
        // stored row arrives on mem_dout exactly when the SFU is presented.
        if (in_valid) begin
          row_d      = in_data;
          mem_cen    = CEN_ON;
          mem_wen    = WEN_RD;
          mem_addr   = addr_q;
          mem_addr_d = addr_q;
          state_d    = S_ACC;
        end
      end

      S_ACC: begin
        sfu_valid    = 1'b1;
        // First pass: the stored contents are stale, so the SFU sees zero.
        sfu_psum_mem = acc_en_q ? mem_dout : '0;
        psum_mem_d   = sfu_psum_mem;
        state_d      = S_WB;
      end

      S_WB: begin
        mem_cen    = CEN_ON;
        mem_wen    = WEN_WR;
        mem_addr   = addr_q;
        mem_din    = sfu_psum_out;
        mem_addr_d = addr_q;
        mem_din_d  = sfu_psum_out;
        row_cnt_d  = row_cnt_q + ONE;
        addr_d     = addr_q + ONE;   // natural wrap at 2^addr_bw
        state_d    = (row_cnt_d == num_rows_q) ? S_FIN : S_RD;
      end

      S_FIN: begin
        // start is not examined here, so a start coincident with done is dropped.
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      row_cnt_q  <= '0;
      num_rows_q <= '0;
      acc_en_q   <= 1'b0;
      row_q      <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      psum_mem_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_cnt_q  <= row_cnt_d;
      num_rows_q <= num_rows_d;
      acc_en_q   <= acc_en_d;
      row_q      <= row_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      psum_mem_q <= psum_mem_d;
    end
  end

endmodule

// File: tb/tb_psum_mem_seq.sv
// tb_psum_mem_seq: directed bench for psum_mem_seq with a behavioural SRAM and SFU adder.
// Latency: n/a. Backpressure: in_valid is held low / randomised in dedicated scenarios.
// Ports: none (top-level bench).
module tb_psum_mem_seq;

  localparam int PB = 32;
  localparam int NC = 8;
  localparam int AW = 11;
  localparam int RW = PB * NC;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_rows;
  logic          acc_en;
  logic          in_valid;
  logic [RW-1:0] in_data;
  logic          in_ready;
  logic          mem_cen;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_din;
  logic [RW-1:0] mem_dout;
  logic          sfu_valid;
  logic [RW-1:0] sfu_psum_in;
  logic [RW-1:0] sfu_psum_mem;
  logic [RW-1:0] sfu_psum_out;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  psum_mem_seq #(.psum_bw(PB), .col(NC), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .acc_en(acc_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .sfu_valid(sfu_valid),
    .sfu_psum_in(sfu_psum_in), .sfu_psum_mem(sfu_psum_mem),
    .sfu_psum_out(sfu_psum_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM with a bench-side preload port.
  logic [RW-1:0] sram [0:(1<<AW)-1];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [RW-1:0] pl_dat = '0;

  always @(posedge clk) begin
    if (pl_we) sram[pl_addr] <= pl_dat;
    else if (!mem_cen) begin
      if (!mem_wen) sram[mem_addr] <= mem_din;
      else          mem_dout <= sram[mem_addr];
    end
  end

  // SFU bank: per-column add, registered one cycle after sfu_valid.
  always @(posedge clk) begin
    if (sfu_valid)
      for (int c = 0; c < NC; c++)
        sfu_psum_out[c*PB +: PB] <= sfu_psum_in[c*PB +: PB] + sfu_psum_mem[c*PB +: PB];
  end

  // Protocol monitor: counts accesses and violations; scenarios compare deltas.
  int          wr_cnt = 0, acc_cnt = 0, sfu_cnt_m = 0, viol = 0;
  logic [AW-1:0] wr_q[$];
  logic        prev_rd = 1'b0, prev_sfu = 1'b0;

  always @(negedge clk) begin
    #2;
    if (reset) begin
      prev_rd  = 1'b0;
      prev_sfu = 1'b0;
    end else begin
      if (!mem_cen) acc_cnt++;
      if (!mem_cen && !mem_wen) begin
        wr_cnt++;
        wr_q.push_back(mem_addr);
        if (prev_rd) viol++;
      end
      if (sfu_valid) sfu_cnt_m++;
      if (sfu_valid && prev_sfu) viol++;
      prev_rd  = !mem_cen && mem_wen;
      prev_sfu = sfu_valid;
    end
  end

  function automatic logic [RW-1:0] fill(input logic [PB-1:0] v);
    logic [RW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*PB +: PB] = v;
    return r;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [RW-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issues start and waits for done with in_valid held as the caller set it.
  // done_at counts negedges after the start-sampling edge (-1 on timeout).
  task automatic run_pass(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic a,
                          output int done_at, output int sfu_seen,
                          output logic [RW-1:0] first_mem, output logic [RW-1:0] first_in);
    done_at = -1; sfu_seen = 0; first_mem = 'x; first_in = 'x;
    @(negedge clk);
    start = 1'b1; base_addr = b; num_rows = n; acc_en = a;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      #1;
      if (sfu_valid) begin
        if (sfu_seen == 0) begin first_mem = sfu_psum_mem; first_in = sfu_psum_in; end
        sfu_seen++;
      end
      if (done) begin done_at = k; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({in_ready, mem_cen, mem_wen, sfu_valid, busy, done} !== 6'b011000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 011000", {in_ready, mem_cen, mem_wen, sfu_valid, busy, done}); end
    n_cmp++; if (mem_addr !== '0 || mem_din !== '0) begin
      n_err++; $display("FAIL reset_mem_bus: addr %0h din %0h want 0", mem_addr, mem_din); end
    n_cmp++; if (sfu_psum_in !== '0 || sfu_psum_mem !== '0) begin
      n_err++; $display("FAIL reset_sfu_bus: in %0h mem %0h want 0", sfu_psum_in, sfu_psum_mem); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int d, s; logic [RW-1:0] fm, fi;
    preload(11'd4, fill(32'd10));
    preload(11'd5, fill(32'd10));
    in_data = fill(32'd3); in_valid = 1'b1;
    run_pass(11'd4, 11'd2, 1'b1, d, s, fm, fi);
    in_valid = 1'b0;
    n_cmp++; if (d !== 7) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 7", d); end
    n_cmp++; if (s !== 2) begin n_err++; $display("FAIL basic_sfu_pulses: got %0d want 2", s); end
    n_cmp++; if (fm !== fill(32'd10)) begin n_err++; $display("FAIL basic_psum_mem: got %0h want all 10", fm); end
    n_cmp++; if (fi !== fill(32'd3)) begin n_err++; $display("FAIL basic_psum_in: got %0h want all 3", fi); end
    @(negedge clk);
    n_cmp++; if (sram[4] !== fill(32'd13)) begin n_err++; $display("FAIL basic_row4: got %0h want all 13", sram[4]); end
    n_cmp++; if (sram[5] !== fill(32'd13)) begin n_err++; $display("FAIL basic_row5: got %0h want all 13", sram[5]); end
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_first_pass;
    int d, s; logic [RW-1:0] fm, fi, row;
    for (int c = 0; c < NC; c++) row[c*PB +: PB] = 32'(100 + c);
    preload(11'd4, fill(32'd99));
    in_data = row; in_valid = 1'b1;
    run_pass(11'd4, 11'd1, 1'b0, d, s, fm, fi);
    in_valid = 1'b0;
    n_cmp++; if (fm !== '0) begin n_err++; $display("FAIL first_psum_mem: got %0h want 0", fm); end
    n_cmp++; if (d !== 4) begin n_err++; $display("FAIL first_done_cycle: got %0d want 4", d); end
    @(negedge clk);
    n_cmp++; if (sram[4] !== row) begin n_err++; $display("FAIL first_row4: got %0h want %0h", sram[4], row); end
  endtask

  task automatic test_backpressure;
    int d = -1;
    preload(11'd6, fill(32'd1));
    in_valid = 1'b0; in_data = fill(32'd4);
    @(negedge clk);
    start = 1'b1; base_addr = 11'd6; num_rows = 11'd1; acc_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready c%0d: got %b want 1", k, in_ready); end
      n_cmp++; if (mem_cen !== 1'b1) begin n_err++; $display("FAIL bp_cen c%0d: got %b want 1", k, mem_cen); end
      n_cmp++; if (sfu_valid !== 1'b0) begin n_err++; $display("FAIL bp_sfu c%0d: got %b want 0", k, sfu_valid); end
    end
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    n_cmp++; if ({mem_cen, mem_wen, mem_addr} !== {1'b0, 1'b1, 11'd6}) begin
      n_err++; $display("FAIL bp_read_issue: cen %b wen %b addr %0d want 0 1 6", mem_cen, mem_wen, mem_addr); end
    for (int k = 7; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (done) begin d = k; break; end
    end
    n_cmp++; if (d !== 9) begin n_err++; $display("FAIL bp_done_cycle: got %0d want 9", d); end
    @(negedge clk);
    n_cmp++; if (sram[6] !== fill(32'd5)) begin n_err++; $display("FAIL bp_row6: got %0h want all 5", sram[6]); end
  endtask

  task automatic test_wrap_and_empty;
    int d, s, w0, a0; logic [RW-1:0] fm, fi;
    preload(11'd2047, fill(32'd1));
    preload(11'd0, fill(32'd2));
    preload(11'd1, fill(32'd55));
    in_data = fill(32'd5); in_valid = 1'b1;
    w0 = wr_q.size();
    run_pass(11'd2047, 11'd2, 1'b1, d, s, fm, fi);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr_q.size() - w0 !== 2) begin n_err++; $display("FAIL wrap_writes: got %0d want 2", wr_q.size() - w0); end
    else begin
      n_cmp++; if (wr_q[w0] !== 11'd2047 || wr_q[w0+1] !== 11'd0) begin
        n_err++; $display("FAIL wrap_addrs: got %0d,%0d want 2047,0", wr_q[w0], wr_q[w0+1]); end
    end
    n_cmp++; if (sram[2047] !== fill(32'd6) || sram[0] !== fill(32'd7)) begin
      n_err++; $display("FAIL wrap_data: got %0h / %0h want all 6 / all 7", sram[2047], sram[0]); end
    n_cmp++; if (sram[1] !== fill(32'd55)) begin n_err++; $display("FAIL wrap_row1_untouched: got %0h", sram[1]); end
    // Empty pass: IDLE goes straight to FIN, so done follows the start edge.
    a0 = acc_cnt;
    run_pass(11'd9, 11'd0, 1'b1, d, s, fm, fi);
    n_cmp++; if (d !== 1) begin n_err++; $display("FAIL empty_done_cycle: got %0d want 1", d); end
    @(negedge clk); #3;
    n_cmp++; if (acc_cnt - a0 !== 0) begin n_err++; $display("FAIL empty_sram_access: got %0d want 0", acc_cnt - a0); end
  endtask

  task automatic test_reset_mid;
    int d, s; logic [RW-1:0] fm, fi;
    preload(11'd8, fill(32'd20));
    in_data = fill(32'd1); in_valid = 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = 11'd8; num_rows = 11'd1; acc_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (sfu_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_acc: sfu_valid %b want 1", sfu_valid); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({in_ready, mem_cen, mem_wen, sfu_valid, busy, done} !== 6'b011000) begin
      n_err++; $display("FAIL rst_mid_ctrl: got %b want 011000", {in_ready, mem_cen, mem_wen, sfu_valid, busy, done}); end
    n_cmp++; if (mem_addr !== '0 || sfu_psum_in !== '0 || sfu_psum_mem !== '0 || mem_din !== '0) begin
      n_err++; $display("FAIL rst_mid_buses: addr %0h in %0h mem %0h din %0h want 0", mem_addr, sfu_psum_in, sfu_psum_mem, mem_din); end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (sram[8] !== fill(32'd20)) begin n_err++; $display("FAIL rst_mid_row8_kept: got %0h want all 20", sram[8]); end
    in_valid = 1'b1;
    run_pass(11'd8, 11'd1, 1'b1, d, s, fm, fi);
    in_valid = 1'b0;
    n_cmp++; if (d !== 4) begin n_err++; $display("FAIL rst_mid_restart_done: got %0d want 4", d); end
    @(negedge clk);
    n_cmp++; if (sram[8] !== fill(32'd21)) begin n_err++; $display("FAIL rst_mid_restart_row8: got %0h want all 21", sram[8]); end
  endtask

  task automatic test_protocol;
    int d = -1, w0, s0, v0, n;
    logic [AW-1:0] b;
    b = AW'($urandom_range(200, 1000));
    n = $urandom_range(3, 6);
    preload(11'd100, fill(32'd77));
    in_data = fill(32'd9);
    w0 = wr_q.size(); s0 = sfu_cnt_m; v0 = viol;
    @(negedge clk);
    start = 1'b1; base_addr = b; num_rows = AW'(n); acc_en = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin base_addr = 11'd100; num_rows = 11'd5; acc_en = 1'b1; end
      in_valid = 1'($urandom_range(0, 1));
      #1;
      if (done) begin d = k; break; end
    end
    in_valid = 1'b0;
    n_cmp++; if (d < 0) begin n_err++; $display("FAIL proto_timeout: no done within 300 cycles"); end
    repeat (3) @(negedge clk);
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL proto_start_ignored_busy: got %b want 0", busy); end
    n_cmp++; if (viol - v0 !== 0) begin n_err++; $display("FAIL proto_violations: got %0d want 0", viol - v0); end
    n_cmp++; if (sfu_cnt_m - s0 !== n) begin n_err++; $display("FAIL proto_sfu_pulses: got %0d want %0d", sfu_cnt_m - s0, n); end
    n_cmp++; if (wr_q.size() - w0 !== n) begin n_err++; $display("FAIL proto_writes: got %0d want %0d", wr_q.size() - w0, n); end
    else begin
      for (int i = 0; i < n; i++) begin
        n_cmp++; if (wr_q[w0+i] !== AW'(b + AW'(i))) begin
          n_err++; $display("FAIL proto_wr_addr%0d: got %0d want %0d", i, wr_q[w0+i], AW'(b + AW'(i))); end
        n_cmp++; if (sram[AW'(b + AW'(i))] !== fill(32'd9)) begin
          n_err++; $display("FAIL proto_row%0d: got %0h want all 9", i, sram[AW'(b + AW'(i))]); end
      end
    end
    n_cmp++; if (sram[100] !== fill(32'd77)) begin n_err++; $display("FAIL proto_row100_untouched: got %0h", sram[100]); end
  endtask

  initial begin
    start = 1'b0; base_addr = '0; num_rows = '0; acc_en = 1'b0;
    in_valid = 1'b0; in_data = '0; reset = 1'b1;
    test_reset;
    test_basic;
    test_first_pass;
    test_backpressure;
    test_wrap_and_empty;
    test_reset_mid;
    test_protocol;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
